sync_tx_launcher: RTL and testbench
===================================

# sync_tx_launcher

Source-domain launcher that sits directly upstream of the two-flop enable synchronizer. Accepts 4-bit words from a producer over a valid/ready handshake, buffers them in a small FIFO, and drives each word onto a held-stable data bus with a multi-cycle enable pulse. Data stays stable long enough for the destination domain to sample it after enable synchronization. All logic runs in the source clock domain.

## Interface
- DW, 4: data width; matches the synchronizer data input.
- DEPTH, 4: FIFO depth in words; power of two, 2..16.
- SETUP, 1: cycles data_out is stable before data_en rises; 1..255.
- HOLD, 4: cycles data_en stays high; 1..255; must cover at least 3 destination-clock periods.
- SETTLE, 4: cycles data_out stays stable after data_en falls; 1..255.

- clk_a  in  1  source clock; all state updates on the rising edge.
- arst  in  1  asynchronous reset, active-high.
- in_data  in  DW  producer word.
- in_valid  in  1  producer word valid.
- in_ready  out  1  FIFO can accept; equals !full from registered state.
- data_out  out  DW  launched word; feeds synchronizer data_in.
- data_en  out  1  launch enable; feeds synchronizer data_en.
- busy  out  1  state != IDLE or FIFO not empty.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Push when in_valid && in_ready at the rising edge. in_ready depends only on registered occupancy and has no combinational path from in_valid or the pop.
- FSM: IDLE, SETUP, ASSERT, SETTLE. A single 8-bit down-counter cnt is shared.
- IDLE: if FIFO is non-empty, pop the head, load data_out, set cnt=SETUP-1, and go to SETUP. Otherwise stay in IDLE.
- SETUP: data_en=0. When cnt==0, set cnt=HOLD-1 and go to ASSERT. Otherwise decrement.
- ASSERT: data_en=1. When cnt==0, set cnt=SETTLE-1 and go to SETTLE. Otherwise decrement.
- SETTLE: data_en=0. When cnt==0, go to IDLE. Otherwise decrement.
- data_out changes only on the IDLE→SETUP transition. It retains the last word while IDLE.
- data_en is a registered output. It is high exactly in ASSERT and glitch-free.
- Simultaneous push and pop: occupancy is unchanged. The pushed word is written behind the popped head.
- Push while full cannot occur, because in_ready=0. A producer that holds in_valid simply waits.
- Pointers wrap modulo DEPTH. Occupancy is tracked separately so full and empty are unambiguous.

## Timing
- Reset values, applied asynchronously the moment arst rises: in_ready=1, data_out=0, data_en=0, busy=0, fifo_level=0, state=IDLE, FIFO emptied.
- Reset mid-launch: data_en drops immediately and the buffered words are discarded.
- Latency:
  - Word accepted at edge E into an empty FIFO with FSM in IDLE.
  - fifo_level=1 after E.
  - data_out is updated at E+1.
  - data_en rises at E+1+SETUP and falls at E+1+SETUP+HOLD.
  - FSM returns to IDLE at E+1+SETUP+HOLD+SETTLE.
- Back-to-back launch period: 1+SETUP+HOLD+SETTLE cycles (10 at defaults). IDLE always occupies at least one cycle.
- Consecutive data_en pulses are separated by at least SETTLE+1+SETUP low cycles.

## Configuration
- SYNC_TX_LAUNCHER_STATS_EN
- Defined:
  - Adds output launch_count [15:0], which increments by 1 on every IDLE→SETUP transition and wraps 0xFFFF→0x0000.
  - Adds output full_stall [15:0], which increments each cycle that in_valid=1 and in_ready=0, and saturates at 0xFFFF.
  - Both counters reset to 0 on arst.
- Undefined: neither output exists and no counter logic is present.

## Test plan
- Reset: hold arst, then release → in_ready=1, data_en=0, data_out=0, fifo_level=0, busy=0.
- Single word 0xA at edge E, defaults → data_out=0xA at E+1; data_en high for exactly E+2..E+5 (4 cycles); busy=0 after E+10.
- Burst 0x1,0x2,0x3,0x4,0x5 pushed on consecutive cycles:
  - in_ready goes low when fifo_level=4, since the first word pops at E+1.
  - Launches occur in order with 10-cycle spacing.
  - No word is lost or duplicated.
- Full FIFO with push and pop in the same cycle → fifo_level stays 4 and order is preserved.
- arst asserted during ASSERT → data_en=0 immediately, fifo_level=0, no further launches.
- Stats build, 3 words launched with 5 stalled cycles → launch_count=3, full_stall=5.

Source files
------------

// File: rtl/sync_tx_launcher.sv
// Source-domain launcher: buffers producer words and presents each on a held-stable bus with a multi-cycle enable.
// Optional SYNC_TX_LAUNCHER_STATS_EN adds launch_count and full_stall counters.
module sync_tx_launcher #(
    parameter int unsigned DW     = 4,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETUP  = 1,
    parameter int unsigned HOLD   = 4,
    parameter int unsigned SETTLE = 4
) (
    input  logic                     clk_a,
    input  logic                     arst,
    input  logic [DW-1:0]            in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DW-1:0]            data_out,
    output logic                     data_en,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef SYNC_TX_LAUNCHER_STATS_EN
    ,
    output logic [15:0]              launch_count,
    output logic [15:0]              full_stall
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [7:0]    SETUP_LD  = 8'(SETUP - 1);
    localparam logic [7:0]    HOLD_LD   = 8'(HOLD - 1);
    localparam logic [7:0]    SETTLE_LD = 8'(SETTLE - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ASSERT = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [7:0]      cnt, cnt_nx;
    logic            pop, push;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [DW-1:0]   mem [DEPTH];
    logic [LW-1:0]   level_nx;

    assign push = in_valid && in_ready;

    // Occupancy is tracked explicitly so full and empty never alias.
    always_comb begin
        level_nx = fifo_level;
        if (push && !pop) begin
            level_nx = fifo_level + LW'(1);
        end else if (!push && pop) begin
            level_nx = fifo_level - LW'(1);
        end
    end

    // Launch sequencer: one shared down-counter times each phase.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fifo_level != '0) begin
                    pop      = 1'b1;
                    cnt_nx   = SETUP_LD;
                    state_nx = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt == 8'd0) begin
                    cnt_nx   = HOLD_LD;
                    state_nx = ST_ASSERT;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            ST_ASSERT: begin
                if (cnt == 8'd0) begin
                    cnt_nx   = SETTLE_LD;
                    state_nx = ST_SETTLE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt == 8'd0) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_a or posedge arst) begin
        if (arst) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Registered outputs are computed from next-state values so they track the FSM without glitches.
    always_ff @(posedge clk_a or posedge arst) begin
        if (arst) begin
            fifo_level <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            data_en    <= 1'b0;
            data_out   <= '0;
        end else begin
            fifo_level <= level_nx;
            in_ready   <= (level_nx != LVL_FULL);
            busy       <= (state_nx != ST_IDLE) || (level_nx != '0);
            data_en    <= (state_nx == ST_ASSERT);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk_a) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

`ifdef SYNC_TX_LAUNCHER_STATS_EN
    // launch_count wraps; full_stall saturates.
    always_ff @(posedge clk_a or posedge arst) begin
        if (arst) begin
            launch_count <= 16'd0;
            full_stall   <= 16'd0;
        end else begin
            if (pop) begin
                launch_count <= launch_count + 16'd1;
            end
            if (in_valid && !in_ready && (full_stall != 16'hFFFF)) begin
                full_stall <= full_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_tx_launcher.sv
// Self-checking bench for sync_tx_launcher: vector table for single launches, scoreboard for launch order.
module tb_sync_tx_launcher;

    localparam int unsigned DW     = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SETUP  = 1;
    localparam int unsigned HOLD   = 4;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned LW     = $clog2(DEPTH) + 1;

    logic          clk_a = 1'b0;
    logic          arst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] data_out;
    logic          data_en;
    logic          busy;
    logic [LW-1:0] fifo_level;
`ifdef SYNC_TX_LAUNCHER_STATS_EN
    logic [15:0]   launch_count;
    logic [15:0]   full_stall;
`endif

    sync_tx_launcher #(
        .DW(DW), .DEPTH(DEPTH), .SETUP(SETUP), .HOLD(HOLD), .SETTLE(SETTLE)
    ) dut (
        .clk_a(clk_a),
        .arst(arst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_out(data_out),
        .data_en(data_en),
        .busy(busy),
        .fifo_level(fifo_level)
`ifdef SYNC_TX_LAUNCHER_STATS_EN
        ,
        .launch_count(launch_count),
        .full_stall(full_stall)
`endif
    );

    always #5 clk_a = ~clk_a;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    logic [DW-1:0] sb [$];
    int rises [$];
    int n_launch = 0;
    int max_level = 0;
    logic en_prev = 1'b0;
    logic seen_pulse = 1'b0;
    int en_len = 0;
    int low_len = 0;

    typedef struct {
        logic [DW-1:0] word;
        logic [DW-1:0] exp_data;
        int            exp_rise;
        int            exp_len;
        int            exp_done;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_a) cyc++;

    // Monitor: launch order against scoreboard, pulse width, low gap, ready/level relation.
    always @(negedge clk_a) begin
        if (arst) begin
            en_prev    = 1'b0;
            seen_pulse = 1'b0;
            en_len     = 0;
            low_len    = 0;
            n_launch   = 0;
        end else begin
            chk("ready_vs_level", 32'(in_ready), 32'(fifo_level != LW'(DEPTH)));
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (data_en) begin
                if (!en_prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_launch", 32'(1), 32'(0));
                    end else begin
                        chk("launch_data", 32'(data_out), 32'(sb.pop_front()));
                    end
                    if (seen_pulse) chk("low_gap", 32'(low_len >= int'(SETTLE + 1 + SETUP)), 32'(1));
                    rises.push_back(cyc);
                    n_launch++;
                    en_len = 0;
                end
                en_len++;
            end else begin
                if (en_prev) begin
                    chk("pulse_len", 32'(en_len), 32'(HOLD));
                    seen_pulse = 1'b1;
                    low_len    = 0;
                end
                low_len++;
            end
            en_prev = data_en;
        end
    end

    task automatic push_word(input logic [DW-1:0] w);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && guard < 200) begin
            @(posedge clk_a); #1;
            guard++;
        end
        if (!in_ready) chk("push_timeout", 32'(1), 32'(0));
        else sb.push_back(w);
        @(posedge clk_a); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int n);
        int i = 0;
        while ((busy || data_en) && i < n) begin
            @(posedge clk_a); #1;
            i++;
        end
        if (busy || data_en) chk("idle_timeout", 32'(1), 32'(0));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(1));
        chk({tag, "_data_en"}, 32'(data_en), 32'(0));
        chk({tag, "_data_out"}, 32'(data_out), 32'(0));
        chk({tag, "_level"}, 32'(fifo_level), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
`ifdef SYNC_TX_LAUNCHER_STATS_EN
        chk({tag, "_launch_count"}, 32'(launch_count), 32'(0));
        chk({tag, "_full_stall"}, 32'(full_stall), 32'(0));
`endif
    endtask

    initial begin
        logic [DW-1:0] prev_out;
        int r0;
        int rise;
        int len;
        int done;
        int guard;

        vecs[0] = '{4'hA, 4'hA, int'(1 + SETUP), int'(HOLD), int'(1 + SETUP + HOLD + SETTLE)};
        vecs[1] = '{4'h0, 4'h0, int'(1 + SETUP), int'(HOLD), int'(1 + SETUP + HOLD + SETTLE)};
        vecs[2] = '{4'hF, 4'hF, int'(1 + SETUP), int'(HOLD), int'(1 + SETUP + HOLD + SETTLE)};
        vecs[3] = '{4'h5, 4'h5, int'(1 + SETUP), int'(HOLD), int'(1 + SETUP + HOLD + SETTLE)};
        vecs[4] = '{4'h3, 4'h3, int'(1 + SETUP), int'(HOLD), int'(1 + SETUP + HOLD + SETTLE)};

        arst     = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk_a);
        #1;
        chk_reset_state("rst_held");
        arst = 1'b0;
        repeat (2) @(posedge clk_a);
        #1;
        chk_reset_state("rst_released");

        // Single launches from idle.
        prev_out = '0;
        for (int v = 0; v < 5; v++) begin
            in_valid = 1'b1;
            in_data  = vecs[v].word;
            sb.push_back(vecs[v].word);
            @(posedge clk_a); #1;
            in_valid = 1'b0;
            chk("level_after_push", 32'(fifo_level), 32'(1));
            chk("data_out_retained", 32'(data_out), 32'(prev_out));
            rise = -1;
            len  = 0;
            done = -1;
            for (int k = 1; k <= vecs[v].exp_done + 2; k++) begin
                @(posedge clk_a); #1;
                if (k == 1) chk("data_out_load", 32'(data_out), 32'(vecs[v].exp_data));
                if (data_en) begin
                    if (rise < 0) rise = k;
                    len++;
                end
                if (!busy && done < 0) done = k;
            end
            chk("en_rise_cycle", 32'(rise), 32'(vecs[v].exp_rise));
            chk("en_high_cycles", 32'(len), 32'(vecs[v].exp_len));
            chk("busy_low_cycle", 32'(done), 32'(vecs[v].exp_done));
            prev_out = vecs[v].word;
        end

        // Burst into a full FIFO, then a held producer refills behind each pop.
        r0 = rises.size();
        for (int i = 1; i <= 5; i++) begin
            push_word(DW'(i));
            if (i == 2) chk("push_pop_level", 32'(fifo_level), 32'(1));
        end
        chk("burst_level_full", 32'(fifo_level), 32'(DEPTH));
        chk("burst_ready_low", 32'(in_ready), 32'(0));
        push_word(4'h6);
        push_word(4'h7);
        wait_idle(300);
        chk("burst_launches", 32'(rises.size() - r0), 32'(7));
        for (int i = r0 + 1; i < rises.size(); i++) begin
            chk("burst_spacing", 32'(rises[i] - rises[i-1]), 32'(1 + SETUP + HOLD + SETTLE));
        end
        chk("max_level", 32'(max_level), 32'(DEPTH));
        chk("sb_drained_burst", 32'(sb.size()), 32'(0));

        // Reset while the enable is high.
        push_word(4'hB);
        push_word(4'hC);
        push_word(4'hD);
        chk("pre_reset_level", 32'(fifo_level), 32'(2));
        guard = 0;
        while (!data_en && guard < 50) begin
            @(posedge clk_a); #1;
            guard++;
        end
        chk("reached_assert", 32'(data_en), 32'(1));
        #2;
        arst = 1'b1;
        #1;
        chk_reset_state("rst_mid_assert");
        sb.delete();
        @(posedge clk_a); #1;
        arst = 1'b0;
        repeat (30) @(posedge clk_a);
        #1;
        chk("no_launch_after_reset", 32'(n_launch), 32'(0));
        chk("level_after_reset", 32'(fifo_level), 32'(0));

        // Five launches plus five stalled cycles with a sixth word held against a full FIFO.
        for (int i = 8; i <= 12; i++) push_word(DW'(i));
        in_valid = 1'b1;
        in_data  = 4'hD;
        repeat (5) @(posedge clk_a);
        #1;
        in_valid = 1'b0;
        wait_idle(300);
        chk("stall_phase_launches", 32'(n_launch), 32'(5));
`ifdef SYNC_TX_LAUNCHER_STATS_EN
        chk("launch_count", 32'(launch_count), 32'(5));
        chk("full_stall", 32'(full_stall), 32'(5));
`endif
        chk("sb_drained_end", 32'(sb.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
